// File: rtl/dmem_mmio.sv
// Data-memory stage for the pipelined ARM core: word RAM with byte-lane
// stores plus a four-register MMIO window (cycle counter, LEDs, store
// counter, sticky access-error flag). Loads are combinational.
module dmem_mmio #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        BEDmem,
  output logic [31:0] ReadData,
  output logic [7:0]  Led,
  output logic        Err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] REG_CYCLE  = 2'd0;
  localparam logic [1:0] REG_LED    = 2'd1;
  localparam logic [1:0] REG_STORES = 2'd2;
  localparam logic [1:0] REG_ERR    = 2'd3;

  logic [31:0]   mem [DEPTH];

  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] idx;
  logic [1:0]    reg_sel;
  logic [1:0]    lane;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic          err_set;
  logic          err_clr;

  logic [31:0]   cycle_q, cycle_d;
  logic [7:0]    led_q, led_d;
  logic [31:0]   stores_q, stores_d;
  logic          err_q, err_d;

  assign ram_hit  = (ALUResult[31:AW+2] == '0);
  assign mmio_hit = (ALUResult[31:4] == MMIO_BASE[31:4]);
  assign idx      = ALUResult[AW+1:2];
  assign reg_sel  = ALUResult[3:2];
  assign lane     = ALUResult[1:0];

  // Store lane enables and lane-replicated store data for the RAM
  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = BEDmem ? {4{WriteData[7:0]}} : WriteData;
    if (MemWrite && ram_hit)
      ram_be = BEDmem ? (4'b0001 << lane) : 4'b1111;
  end

  // RAM write port; gating on reset drops a store caught by reset at the edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[idx][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  // Load path: select word source, then optional byte-lane extraction
  always_comb begin
    rd_word = 32'h0;
    if (ram_hit) begin
      rd_word = mem[idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_CYCLE:  rd_word = cycle_q;
        REG_LED:    rd_word = {24'h0, led_q};
        REG_STORES: rd_word = stores_q;
        default:    rd_word = {31'h0, err_q};
      endcase
    end
    rd_shift = rd_word >> {lane, 3'b000};
    ReadData = BEDmem ? {24'h0, rd_shift[7:0]} : rd_word;
  end

  // Next-state for MMIO registers and the error flag (set beats clear)
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    led_d    = led_q;
    stores_d = stores_q;
    err_set  = (!BEDmem && (lane != 2'b00) && (MemWrite || ram_hit || mmio_hit))
             || (MemWrite && !ram_hit && !mmio_hit);
    err_clr  = MemWrite && mmio_hit && (reg_sel == REG_ERR) && !WriteData[0];
    if (MemWrite && mmio_hit && (reg_sel == REG_CYCLE)) cycle_d = 32'h0;
    if (MemWrite && mmio_hit && (reg_sel == REG_LED))   led_d   = WriteData[7:0];
    if (MemWrite && ram_hit) stores_d = stores_q + 32'd1;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // MMIO register state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q  <= 32'h0;
      led_q    <= 8'h0;
      stores_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      led_q    <= led_d;
      stores_q <= stores_d;
      err_q    <= err_d;
    end
  end

  assign Led = led_q;
  assign Err = err_q;

endmodule
